// File: rtl/tcdm_bank_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the TCDM bank arbiter.
// Request fields are sized to the widest supported bus; the top narrows them.
package tcdm_arb_pkg;

    localparam int TCDM_MAX_AW = 64;
    localparam int TCDM_MAX_DW = 128;
    localparam int BE_WIDTH    = TCDM_MAX_DW / 8;
    localparam int RR_MAX_REQ  = 16;
    localparam int RR_IDX_W    = 4;

    typedef struct packed {
        logic [TCDM_MAX_AW-1:0] add;
        logic                   wen;
        logic [BE_WIDTH-1:0]    be;
        logic [TCDM_MAX_DW-1:0] data;
    } tcdm_req_t;

    // Returns {found, index}: first set bit of req scanning ptr, ptr+1, ... mod n.
    function automatic logic [RR_IDX_W:0] rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                                  input logic [RR_IDX_W-1:0]   ptr,
                                                  input int                    n);
        logic [RR_IDX_W:0] res;
        int j;
        res = '0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (i < n && !res[RR_IDX_W] && req[j[RR_IDX_W-1:0]])
                res = {1'b1, j[RR_IDX_W-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/tcdm_bank_arbiter_if.sv
// Requester-side and bank-side signals of the TCDM bank arbiter.
// slave = arbiter view, master = requesters plus bank model view.
interface tcdm_bank_arbiter_if #(
    parameter int NB_REQ     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int BANK_AW    = 8,
    parameter int DATA_WIDTH = 32
);
    logic [NB_REQ-1:0]              req_i;
    logic [NB_REQ*ADDR_WIDTH-1:0]   add_i;
    logic [NB_REQ-1:0]              wen_i;
    logic [NB_REQ*DATA_WIDTH/8-1:0] be_i;
    logic [NB_REQ*DATA_WIDTH-1:0]   data_i;
    logic [NB_REQ-1:0]              gnt_o;
    logic [NB_REQ-1:0]              r_valid_o;
    logic [DATA_WIDTH-1:0]          r_data_o;

    logic                           bank_req_o;
    logic [BANK_AW-1:0]             bank_add_o;
    logic                           bank_wen_o;
    logic [DATA_WIDTH/8-1:0]        bank_be_o;
    logic [DATA_WIDTH-1:0]          bank_data_o;
    logic [DATA_WIDTH-1:0]          bank_q_i;

    modport slave (
        input  req_i, add_i, wen_i, be_i, data_i, bank_q_i,
        output gnt_o, r_valid_o, r_data_o,
               bank_req_o, bank_add_o, bank_wen_o, bank_be_o, bank_data_o
    );

    modport master (
        output req_i, add_i, wen_i, be_i, data_i, bank_q_i,
        input  gnt_o, r_valid_o, r_data_o,
               bank_req_o, bank_add_o, bank_wen_o, bank_be_o, bank_data_o
    );
endinterface

// File: rtl/tcdm_bank_arbiter_core.sv
// Round-robin pointer plus same-cycle pick; the pointer moves past each winner.
module rr_arbiter_core
    import tcdm_arb_pkg::*;
#(
    parameter int NB_REQ = 4,
    parameter int IDX_W  = $clog2(NB_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NB_REQ-1:0] req,
    output logic [NB_REQ-1:0] gnt,
    output logic [IDX_W-1:0]  winner,
    output logic              found
);

    logic [IDX_W-1:0]  rr_ptr;
    logic [RR_IDX_W:0] pick;
    logic              unused_pick;

    assign pick        = rr_pick(RR_MAX_REQ'(req), RR_IDX_W'(rr_ptr), NB_REQ);
    assign found       = pick[RR_IDX_W];
    assign winner      = pick[IDX_W-1:0];
    assign unused_pick = ^pick;

    always_comb begin
        gnt = '0;
        if (found) gnt[winner] = 1'b1;
    end

    // Explicit wrap so non-power-of-two requester counts stay in range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (found)
            rr_ptr <= (winner == IDX_W'(NB_REQ - 1)) ? '0 : winner + 1'b1;
    end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Shares one 1-cycle-latency TCDM bank among NB_REQ requesters, round-robin.
// Optional perf counters (conflict/access) are built with TCDM_ARB_PERF_EN.
module tcdm_bank_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int NB_REQ     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int BANK_AW    = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pwdn_i,
`ifdef TCDM_ARB_PERF_EN
    input  logic                perf_clr_i,
    output logic [31:0]         conflict_cnt_o,
    output logic [31:0]         access_cnt_o,
`endif
    tcdm_bank_arbiter_if.slave  bus
);

    localparam int IDX_W  = $clog2(NB_REQ);
    localparam int BYTE_W = DATA_WIDTH / 8;

    logic [NB_REQ-1:0] cand;
    logic [NB_REQ-1:0] gnt;
    logic [IDX_W-1:0]  winner;
    logic              found;
    tcdm_req_t         reqs [NB_REQ];
    tcdm_req_t         win;
    logic              unused_win;
    logic              resp_valid;
    logic [IDX_W-1:0]  resp_idx;

    // Reset gating keeps grants and the bank enable low while rst_i is held.
    assign cand = bus.req_i & ~{NB_REQ{pwdn_i | rst_i}};

    rr_arbiter_core #(.NB_REQ(NB_REQ)) u_core (
        .clk    (clk_i),
        .rst    (rst_i),
        .req    (cand),
        .gnt    (gnt),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        for (int k = 0; k < NB_REQ; k++) begin
            reqs[k].add  = TCDM_MAX_AW'(bus.add_i[k*ADDR_WIDTH +: ADDR_WIDTH]);
            reqs[k].wen  = bus.wen_i[k];
            reqs[k].be   = BE_WIDTH'(bus.be_i[k*BYTE_W +: BYTE_W]);
            reqs[k].data = TCDM_MAX_DW'(bus.data_i[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // With no candidate the pick index is 0, so the bank sees requester 0.
    assign win             = reqs[winner];
    assign unused_win      = ^{win.add, win.be, win.data};
    assign bus.gnt_o       = gnt;
    assign bus.bank_req_o  = |cand;
    assign bus.bank_add_o  = win.add[BANK_AW+1:2];
    assign bus.bank_wen_o  = win.wen;
    assign bus.bank_be_o   = win.be[BYTE_W-1:0];
    assign bus.bank_data_o = win.data[DATA_WIDTH-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid <= 1'b0;
            resp_idx   <= '0;
        end else begin
            resp_valid <= found;
            if (found) resp_idx <= winner;
        end
    end

    always_comb begin
        bus.r_valid_o = '0;
        if (resp_valid) bus.r_valid_o[resp_idx] = 1'b1;
    end

    // The bank already registers Q, so read data passes straight through.
    assign bus.r_data_o = bus.bank_q_i;

`ifdef TCDM_ARB_PERF_EN
    logic conflict;

    assign conflict = |(cand & (cand - NB_REQ'(1)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_o <= '0;
            access_cnt_o   <= '0;
        end else if (perf_clr_i) begin
            conflict_cnt_o <= '0;
            access_cnt_o   <= '0;
        end else begin
            if (conflict && conflict_cnt_o != '1) conflict_cnt_o <= conflict_cnt_o + 32'd1;
            if (found) access_cnt_o <= access_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench: stimulus pushes expected responses, a negedge monitor pops them.
module tb_tcdm_bank_arbiter;

    localparam int NB  = 4;
    localparam int AW  = 32;
    localparam int BAW = 8;
    localparam int DW  = 32;

    typedef struct {
        int          idx;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwdn = 1'b0;
`ifdef TCDM_ARB_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] conflict_cnt;
    logic [31:0] access_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [31:0] mem [256];

    tcdm_bank_arbiter_if #(.NB_REQ(NB), .ADDR_WIDTH(AW), .BANK_AW(BAW), .DATA_WIDTH(DW)) bus ();

    tcdm_bank_arbiter #(.NB_REQ(NB), .ADDR_WIDTH(AW), .BANK_AW(BAW), .DATA_WIDTH(DW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pwdn_i         (pwdn),
`ifdef TCDM_ARB_PERF_EN
        .perf_clr_i     (perf_clr),
        .conflict_cnt_o (conflict_cnt),
        .access_cnt_o   (access_cnt),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Bank model: 1-cycle read latency, byte-masked writes.
    always @(posedge clk) begin
        if (bus.bank_req_o) begin
            if (bus.bank_wen_o)
                bus.bank_q_i <= mem[bus.bank_add_o];
            else
                for (int b = 0; b < 4; b++)
                    if (bus.bank_be_o[b]) mem[bus.bank_add_o][b*8 +: 8] <= bus.bank_data_o[b*8 +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.r_valid_o != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got %b required none at %0t", bus.r_valid_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("r_valid", 32'(bus.r_valid_o), 32'(1 << mon_e.idx));
                if (mon_e.rd) chk("r_data", bus.r_data_o, mon_e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [31:0] a);
        bus.add_i[k*32 +: 32] = a;
        bus.wen_i[k]          = 1'b1;
        bus.be_i[k*4 +: 4]    = 4'hF;
        bus.data_i[k*32 +: 32] = 32'h0;
    endtask

    task automatic gnt_chk(input int w, input bit rd, input logic [31:0] d, input logic [7:0] wa);
        exp_t e;
        #2;
        chk("gnt", 32'(bus.gnt_o), 32'(1 << w));
        chk("bank_req", 32'(bus.bank_req_o), 32'd1);
        chk("bank_add", 32'(bus.bank_add_o), 32'(wa));
        e.idx  = w;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'hA000_0000 | 32'(i);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        mem[8'h20]   = 32'h1122_3344;
        bus.bank_q_i = '0;
        bus.req_i    = '0;
        for (int k = 0; k < NB; k++) set_rd(k, 32'(4 * k));

        // reset state, requests gated off while rst is high
        bus.req_i = 4'b1111;
        #3;
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst_bank_req", 32'(bus.bank_req_o), 32'd0);
        chk("rst_r_valid", 32'(bus.r_valid_o), 32'd0);
        bus.req_i = '0;
        step();
        rst = 1'b0;

        // single requester read at 0x40
        set_rd(0, 32'h40);
        bus.req_i = 4'b0001;
        gnt_chk(0, 1'b1, init_val(16), 8'h10);
        chk("single_wen", 32'(bus.bank_wen_o), 32'd1);
        step();
        bus.req_i = '0;
        set_rd(0, 32'h0);
        step();

        // all four from reset: order 0,1,2,3,0,1,2,3
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_i = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            gnt_chk(i % 4, 1'b1, init_val(i % 4), 8'(i % 4));
            step();
        end
        bus.req_i = '0;

        // ptr -> 3 then 1001: 3 wins, then 0
        bus.req_i = 4'b0100;
        gnt_chk(2, 1'b1, init_val(2), 8'd2);
        step();
        bus.req_i = 4'b1001;
        gnt_chk(3, 1'b1, init_val(3), 8'd3);
        step();
        bus.req_i = 4'b0001;
        gnt_chk(0, 1'b1, init_val(0), 8'd0);
        step();
        bus.req_i = '0;

        // partial write by requester 1, read back by requester 2
        bus.add_i[32 +: 32]  = 32'h80;
        bus.wen_i[1]         = 1'b0;
        bus.be_i[4 +: 4]     = 4'b0011;
        bus.data_i[32 +: 32] = 32'hDEAD_BEEF;
        bus.req_i = 4'b0010;
        gnt_chk(1, 1'b0, 32'h0, 8'h20);
        chk("wr_wen", 32'(bus.bank_wen_o), 32'd0);
        chk("wr_be", 32'(bus.bank_be_o), 32'h3);
        chk("wr_data", bus.bank_data_o, 32'hDEAD_BEEF);
        step();
        set_rd(1, 32'h4);
        set_rd(2, 32'h80);
        bus.req_i = 4'b0100;
        gnt_chk(2, 1'b1, 32'h1122_BEEF, 8'h20);
        step();
        set_rd(2, 32'h8);
        bus.req_i = '0;

        // power-down: pending response still lands, grants resume at ptr 2
        bus.req_i = 4'b0010;
        gnt_chk(1, 1'b1, init_val(1), 8'd1);
        step();
        pwdn = 1'b1;
        bus.req_i = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("pwdn_gnt", 32'(bus.gnt_o), 32'd0);
            chk("pwdn_bank_req", 32'(bus.bank_req_o), 32'd0);
            step();
        end
        pwdn = 1'b0;
        gnt_chk(2, 1'b1, init_val(2), 8'd2);
        step();
        bus.req_i = '0;

        // reset while a response is pending: dropped, ptr back to 0
        bus.req_i = 4'b0001;
        #2;
        chk("pre_rst_gnt", 32'(bus.gnt_o), 32'd1);
        step();
        bus.req_i = 4'b1111;
        rst = 1'b1;
        #1;
        chk("mid_rst_r_valid", 32'(bus.r_valid_o), 32'd0);
        chk("mid_rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("mid_rst_bank_req", 32'(bus.bank_req_o), 32'd0);
        step();
        rst = 1'b0;
        bus.req_i = 4'b1001;
        gnt_chk(0, 1'b1, init_val(0), 8'd0);
        step();
        bus.req_i = '0;

`ifdef TCDM_ARB_PERF_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_i = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            gnt_chk(i % 2, 1'b1, init_val(i % 2), 8'(i % 2));
            step();
        end
        bus.req_i = '0;
        #2;
        chk("conflict_cnt", conflict_cnt, 32'd10);
        chk("access_cnt", access_cnt, 32'd10);
        step();
        bus.req_i = 4'b0011;
        perf_clr  = 1'b1;
        gnt_chk(0, 1'b1, init_val(0), 8'd0);
        step();
        perf_clr  = 1'b0;
        bus.req_i = '0;
        #2;
        chk("clr_conflict_cnt", conflict_cnt, 32'd0);
        chk("clr_access_cnt", access_cnt, 32'd0);
        step();
`endif

        step();
        step();
        chk("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_arbiter.md
Name: tcdm_bank_arbiter

Overview:
- Shares one single-ported TCDM SRAM bank (1-cycle read latency, always-ready) between NB_REQ requesters.
- Round-robin, work-conserving arbitration with a same-cycle grant.
- Registers the winner's index so the bank's read data is returned to the correct requester one cycle later, with a per-requester r_valid.
- Sits between the log-interconnect slave ports and one generic_memory bank instance.

Parameters:
- NB_REQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 32, requester address width.
- BANK_AW, 8, bank word-address width; bank address = add[BANK_AW+1:2].
- DATA_WIDTH, 32, data width; byte enable width = DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- pwdn_i  in  1  bank powered down; no grants while high
- req_i  in  NB_REQ  per-requester request
- add_i  in  NB_REQ*ADDR_WIDTH  byte addresses, requester k at slice k
- wen_i  in  NB_REQ  1=read, 0=write
- be_i  in  NB_REQ*DATA_WIDTH/8  byte enables, active high
- data_i  in  NB_REQ*DATA_WIDTH  write data
- gnt_o  out  NB_REQ  one-hot grant
- r_valid_o  out  NB_REQ  one-hot response valid
- r_data_o  out  DATA_WIDTH  read data, broadcast to all requesters
- bank_req_o  out  1  bank chip enable, active high
- bank_add_o  out  BANK_AW  bank word address
- bank_wen_o  out  1  bank read/write select, 1=read
- bank_be_o  out  DATA_WIDTH/8  bank byte enables
- bank_data_o  out  DATA_WIDTH  bank write data
- bank_q_i  in  DATA_WIDTH  bank read data, valid 1 cycle after an accepted read

Behaviour:
- Reset (async on rst_i rising, held while high):
  - rr_ptr=0; r_valid_o=0; resp_idx=0.
  - gnt_o=0 and bank_req_o=0 while rst_i is high.
- Arbitration is combinational in cycle t.
  - Candidates: req_i & ~{NB_REQ{pwdn_i}}.
  - Winner = first asserted candidate scanning rr_ptr, rr_ptr+1, ... modulo NB_REQ.
  - gnt_o = onehot(winner); at most one bit is ever set.
  - bank_* mux the winner's add/wen/be/data; bank_req_o = |candidates.
  - With no candidate: bank_req_o=0 and bank_* data outputs hold the requester-0 mux value (don't-care).
- Pointer update:
  - On a grant, rr_ptr <= (winner+1) mod NB_REQ on the next edge.
  - No grant leaves rr_ptr unchanged.
  - Wrap: winner=NB_REQ-1 gives rr_ptr=0.
- Response path:
  - On a grant in cycle t, resp_valid and resp_idx=winner are registered.
  - In cycle t+1: r_valid_o[resp_idx]=1 for both reads and writes.
  - r_data_o = bank_q_i unregistered (bank already registers Q); meaningful only for reads.
- Throughput and fairness:
  - Back-to-back grants every cycle.
  - Response of cycle t and grant of cycle t+1 coexist, even for the same requester.
- Requester protocol:
  - A requester holds req/add/wen/be/data stable until it sees gnt.
  - The arbiter never revokes a grant within a cycle.
  - Any requester with req held is served within NB_REQ cycles (no starvation).
- pwdn_i:
  - High in cycle t: no grant in t.
  - A response already registered from t-1 is still delivered in t.
- Reset mid-transfer: a pending r_valid is dropped; requesters must reissue.
- Widths: index registers are $clog2(NB_REQ) bits; modulo is explicit for non-power-of-2 NB_REQ.

Optional Feature:
- Macro TCDM_ARB_PERF_EN.
- When defined:
  - Adds output conflict_cnt_o [31:0]: counts cycles with >=2 candidates. Saturating, not wrapping.
  - Adds output access_cnt_o [31:0]: counts grants, wrapping.
  - Adds input perf_clr_i: synchronous clear; a clear and an increment in the same cycle gives 0.
  - Both counters reset to 0.
- When undefined: none of these ports, counters or logic exist.

Decomposition:
- Package tcdm_arb_pkg: localparam BE_WIDTH, typedef tcdm_req_t (add, wen, be, data), function rr_pick.
- Sub-module rr_arbiter_core: pointer register plus rotate/priority-encode/unrotate, parameterised by NB_REQ. Outputs gnt one-hot and winner index.
- The top module instantiates it and adds the muxing, the response register and the optional counters.

Test Plan:
- Single requester: req_i=0001, read add=0x40 -> gnt_o=0001 same cycle, bank_add_o=0x10; next cycle r_valid_o=0001, r_data_o=mem[0x10].
- All four requesting continuously from reset -> grant order 0,1,2,3,0,1...; one grant per cycle; r_valid_o follows gnt_o with 1-cycle delay.
- rr_ptr=3 with req_i=1001 -> requester 3 wins; rr_ptr becomes 0; requester 0 wins the next cycle.
- Write then read, same address, different requesters: write 0xDEADBEEF with be=0011 over 0x11223344 -> read returns 0x1122BEEF, r_valid on the reader only.
- pwdn_i=1 for 3 cycles with req_i=1111 -> gnt_o=0, bank_req_o=0; a response pending from the prior cycle is still delivered; grants resume at the unchanged rr_ptr.
- rst_i pulsed while r_valid is pending -> r_valid_o=0 immediately, rr_ptr=0. With TCDM_ARB_PERF_EN, 10 cycles of req_i=0011 -> conflict_cnt_o=10, access_cnt_o=10.
